lock_ctrl: RTL

Sequencing controller for the digital lock. Collects three BCD keypad digits, compares them against the stored 12-bit password, and drives the lock state. Owns the password register, including change-password and restore-default sequences, and enforces a timed lockout after repeated wrong attempts. Sits between the keypad decoder and the lock/display outputs.

---
 rtl/lock_pkg.sv | 18 +
 rtl/digit_buf.sv | 29 ++
 rtl/lock_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared types and widths for the digital lock controller.
package lock_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        SET_NEW  = 2'd2,
        LOCKOUT  = 2'd3
    } lock_state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 3;
    localparam int PASS_W     = 12;
    localparam int CNT_W      = 2;

    localparam logic [PASS_W-1:0] DEF_PASS = 12'h123;

endpackage

// File: rtl/digit_buf.sv
// Three-digit BCD entry buffer; new digits shift in at the low end.
module digit_buf
    import lock_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               shift,
    input  logic               clear,
    input  logic [DIGIT_W-1:0] digit,
    output logic [PASS_W-1:0]  buffer,
    output logic [CNT_W-1:0]   entry_cnt
);

    logic accept;

    // Non-BCD codes and digits past the third are dropped silently.
    assign accept = shift && (digit <= 4'd9) && (entry_cnt < CNT_W'(NUM_DIGITS));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            buffer    <= '0;
            entry_cnt <= '0;
        end else if (accept) begin
            buffer    <= {buffer[PASS_W-DIGIT_W-1:0], digit};
            entry_cnt <= entry_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lock_ctrl.sv
// Lock sequencer: code entry, password register, fail lockout and auto-relock.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter logic [PASS_W-1:0] PASS_DEFAULT     = DEF_PASS,
    parameter int                MAX_FAIL         = 3,
    parameter int                LOCKOUT_CYCLES   = 1000,
    parameter int                AUTO_LOCK_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               enter,
    input  logic               lock_req,
    input  logic               set_req,
    input  logic               mode_def,
    output logic               lock,
    output logic               alarm,
    output logic               setting,
    output logic [CNT_W-1:0]   entry_cnt,
    output logic [PASS_W-1:0]  password
);

    localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);
    localparam int IDLE_W = $clog2(AUTO_LOCK_CYCLES + 2);
    localparam logic [IDLE_W-1:0] IDLE_RELOAD = IDLE_W'(AUTO_LOCK_CYCLES);

    lock_state_t       state;
    logic [2:0]        fail_cnt;
    logic [2:0]        fail_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [IDLE_W-1:0] idle;
    logic [PASS_W-1:0] buffer;
    logic              in_entry;
    logic              buf_shift;
    logic              buf_clear;
    logic              full;
    logic              match;
    logic              activity;
    logic              idle_done;

    assign in_entry  = (state == LOCKED) || (state == SET_NEW);
    // enter wins over a same-cycle digit
    assign buf_shift = in_entry && digit_valid && !enter;
    assign buf_clear = (in_entry && enter)
                     || (state == SET_NEW && lock_req)
                     || (state == UNLOCKED && set_req && !mode_def);

    assign full      = (entry_cnt == CNT_W'(NUM_DIGITS));
    assign match     = full && (buffer == password);
    assign fail_nxt  = (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;
    assign activity  = digit_valid || enter || lock_req || set_req || mode_def;
    assign idle_done = (AUTO_LOCK_CYCLES > 0) && (idle == IDLE_W'(1));

    digit_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .shift     (buf_shift),
        .clear     (buf_clear),
        .digit     (digit),
        .buffer    (buffer),
        .entry_cnt (entry_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOCKED;
            fail_cnt <= '0;
            tmr      <= '0;
            idle     <= '0;
            password <= PASS_DEFAULT;
            lock     <= 1'b1;
            alarm    <= 1'b0;
            setting  <= 1'b0;
        end else begin
            case (state)
                LOCKED: begin
                    if (enter) begin
                        if (match) begin
                            state    <= UNLOCKED;
                            lock     <= 1'b0;
                            fail_cnt <= '0;
                            idle     <= IDLE_RELOAD;
                        end else begin
                            fail_cnt <= fail_nxt;
                            if (fail_nxt >= 3'(MAX_FAIL)) begin
                                state <= LOCKOUT;
                                alarm <= 1'b1;
                                tmr   <= TMR_W'(LOCKOUT_CYCLES);
                            end
                        end
                    end
                end
                UNLOCKED: begin
                    if (activity)
                        idle <= IDLE_RELOAD;
                    else if (idle != '0)
                        idle <= idle - IDLE_W'(1);

                    if (mode_def) begin
                        password <= PASS_DEFAULT;
                    end else if (set_req) begin
                        state   <= SET_NEW;
                        setting <= 1'b1;
                    end else if (lock_req || (!activity && idle_done)) begin
                        state <= LOCKED;
                        lock  <= 1'b1;
                    end
                end
                SET_NEW: begin
                    if (enter) begin
                        // a short entry aborts and keeps the old password
                        if (full)
                            password <= buffer;
                        state   <= UNLOCKED;
                        setting <= 1'b0;
                        idle    <= IDLE_RELOAD;
                    end else if (lock_req) begin
                        state   <= LOCKED;
                        lock    <= 1'b1;
                        setting <= 1'b0;
                    end
                end
                LOCKOUT: begin
                    if (tmr <= TMR_W'(1)) begin
                        state    <= LOCKED;
                        alarm    <= 1'b0;
                        fail_cnt <= '0;
                        tmr      <= '0;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: begin
                    state <= LOCKED;
                    lock  <= 1'b1;
                end
            endcase
        end
    end

endmodule
